seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Holds a double-buffered hex display value and scans one digit per slot.
- Features: per-digit decimal points, optional leading-zero blanking, 16-level PWM brightness, and a frame-done pulse.
- Sits between datapath/register logic and the board display pins. Replaces per-digit combinational decoders.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
PRESCALE, 50000, clk cycles per digit slot (>=16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
load  input  1  capture value/dp_in/blank_lz into pending buffer this cycle
blank_lz  input  1  1 = blank leading zero digits
bright  input  4  brightness; on-time = (bright+1)/16 of each slot
seg_n  output  7  segments a..g on bits 0..6, active-low
dp_n  output  1  decimal point, active-low
dig_sel_n  output  NUM_DIGITS  one-cold digit enable
frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset is asynchronous. Under reset:
  - seg_n=7'h7F, dp_n=1, dig_sel_n all 1, frame_done=0.
  - Prescaler=0, digit index=0.
  - Pending and active buffers cleared to 0, blank_lz captured as 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - At terminal count, the digit index increments and wraps NUM_DIGITS-1 -> 0.
  - frame_done pulses on the cycle the index wraps to 0. It is registered and coincides with the first cycle of digit 0.
- Buffering:
  - load=1 copies value, dp_in and blank_lz into the pending buffer. A later load overwrites pending.
  - Pending is copied to active only at a frame wrap, so no torn frames.
  - If load and wrap occur in the same cycle, the load data goes straight to active (bypass).
  - load during reset is ignored.
- Decode (active-high pattern, seg_n = ~pattern):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero blanking (active blank_lz=1):
  - Digit i is blanked when nibbles NUM_DIGITS-1 down to i are all zero and i>0.
  - Digit 0 is never blanked.
  - A blanked digit drives pattern 0 but its dp is still honoured.
  - dig_sel_n still asserts for blanked digits, so scan timing stays uniform.
- PWM:
  - A slot is "on" while prescaler < threshold, where threshold = ((bright+1)*PRESCALE)>>4.
  - bright=15 gives the full slot.
  - bright is sampled continuously; a change takes effect at the next prescaler compare.
  - When off, dig_sel_n is all 1 and seg_n=7'h7F, dp_n=1.
- Ghosting guard: dig_sel_n is forced all 1 on the last prescaler count of every slot, regardless of bright.
- Outputs: all outputs are registered. Outputs reflect a new index or buffer one cycle after the event.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). Scanning restarts at digit 0 on the first clk after release.

Decomposition:
- Package seg7_pkg:
  - 16-entry hex-to-segment constant table and a decode function.
  - SEG_OFF = 7'h7F.
  - Localparam helper for prescaler width, $clog2(PRESCALE).
- Sub-module seg7_hex_decode: combinational nibble + blank -> 7-bit active-low pattern.
- seg7_scan_driver contains the prescaler, index counter, buffers, blanking logic, PWM compare and output registers.

Test Plan:
(Bench uses PRESCALE=16, NUM_DIGITS=4.)
- Reset then load value=16'h12AF, dp_in=4'b0100, bright=15 -> per slot:
  - digit0 seg_n=~71, digit1 seg_n=~77, digit2 seg_n=~5B with dp_n=0, digit3 seg_n=~06.
  - dig_sel_n cycles 1110,1101,1011,0111, each enabled 15 of 16 cycles.
  - frame_done pulses every 64 cycles.
- value=16'h0005, blank_lz=1 -> digits 3..1 seg_n=7F with dig_sel_n still cycling; digit0 seg_n=~6D. Repeat with value=16'h0000 -> digit0 shows ~3F.
- Load 16'h1111 mid-frame at digit 1 -> digits 1..3 still show the old value until wrap; the new value appears from digit 0 after frame_done. Load on the wrap cycle -> the new value is visible in that same frame's digit 0.
- bright=3 -> threshold=4: dig_sel_n low for exactly 4 cycles per slot. bright=0 -> 1 cycle low.
- Assert rst_n=0 during digit 2 -> outputs go to reset values without waiting for clk. After release, digit 0 is selected on the first clk edge and the active buffer is 0 (seg_n=~3F).
- Two loads in one frame (16'hAAAA then 16'hBBBB) -> only 16'hBBBB is displayed after the next wrap.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-high here; the driver inverts them for the common-anode pins.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 15 (F) is listed first, so entry n sits at HEX_SEG[n].
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

  // Counter width for a modulo-n counter; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment pattern; a blanked digit drives every segment off.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg_n_c
);

  always_comb begin
    o_seg_n_c = SEG_OFF;
    if (!i_blank) begin
      o_seg_n_c = ~hex_to_seg(i_nibble);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered value,
// leading-zero blanking, 16-level PWM brightness and a frame-done pulse.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [3:0]              bright,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    frame_done
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned DW = NUM_DIGITS;
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned PW = cnt_width(PRESCALE);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = PW + 5;

  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic          r_wrap_d;

  logic [VW-1:0] r_pend_value;
  logic [DW-1:0] r_pend_dp;
  logic          r_pend_blz;
  logic [VW-1:0] r_act_value;
  logic [DW-1:0] r_act_dp;
  logic          r_act_blz;

  logic          w_presc_tc;
  logic          w_idx_last;
  logic          w_wrap;
  logic [TW-1:0] w_thr_full;
  logic [CW-1:0] w_thr;
  logic          w_on;
  logic [3:0]    w_nib;
  logic          w_dp;
  logic          w_blank;
  logic [6:0]    w_seg_n;

  assign w_presc_tc = (r_presc == PW'(PRESCALE - 1));
  assign w_idx_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap     = w_presc_tc && w_idx_last;

  // Slot timing: prescaler walks each slot, index steps digits at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_wrap_d <= 1'b0;
    end else begin
      r_wrap_d <= w_wrap;
      if (w_presc_tc) begin
        r_presc <= '0;
        r_idx   <= w_idx_last ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Pending/active double buffer; active only changes at a frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blz   <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blz    <= 1'b0;
    end else begin
      if (load) begin
        r_pend_value <= value;
        r_pend_dp    <= dp_in;
        r_pend_blz   <= blank_lz;
      end
      if (w_wrap) begin
        r_act_value <= load ? value    : r_pend_value;
        r_act_dp    <= load ? dp_in    : r_pend_dp;
        r_act_blz   <= load ? blank_lz : r_pend_blz;
      end
    end
  end

  // Current digit select plus leading-zero run scanned from the top digit down.
  always_comb begin
    logic run;
    run     = 1'b1;
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run = run && (r_act_value[4*i +: 4] == 4'h0);
      if (r_idx == IW'(i)) begin
        w_nib   = r_act_value[4*i +: 4];
        w_dp    = r_act_dp[i];
        w_blank = r_act_blz && (i != 0) && run;
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .i_nibble  (w_nib),
    .i_blank   (w_blank),
    .o_seg_n_c (w_seg_n)
  );

  // On-time threshold = (bright+1)/16 of a slot, compared against the live prescaler.
  assign w_thr_full = (TW'(bright) + TW'(1)) * TW'(PRESCALE);
  assign w_thr      = CW'(w_thr_full >> 4);
  assign w_on       = ({1'b0, r_presc} < w_thr);

  // Pin registers; the last count of every slot keeps all digits off to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      dig_sel_n  <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= r_wrap_d;
      if (w_on) begin
        seg_n     <= w_seg_n;
        dp_n      <= ~w_dp;
        dig_sel_n <= w_presc_tc ? '1 : ~(DW'(1) << r_idx);
      end else begin
        seg_n     <= SEG_OFF;
        dp_n      <= 1'b1;
        dig_sel_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver (4 digits, 16-cycle slots)
// against a frame/slot arithmetic model with a load history.
module tb_seg7_scan_driver;

  localparam int P     = 16;
  localparam int N     = 4;
  localparam int FRAME = P * N;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int          s;
    logic [15:0] v;
    logic [3:0]  dp;
    logic        blz;
  } load_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_sel_n;
  logic        frame_done;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    st       = 0;
  load_t hist[$];

  seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_sel_n  (dig_sel_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, st);
    end
  endtask

  // Value shown in frame f is the newest load captured before that frame began.
  task automatic active_for(input int f, output logic [15:0] v, output logic [3:0] dpv,
                            output logic blz);
    v = '0; dpv = '0; blz = 1'b0;
    foreach (hist[k]) begin
      if (hist[k].s < f * FRAME) begin
        v = hist[k].v; dpv = hist[k].dp; blz = hist[k].blz;
      end
    end
  endtask

  task automatic check_outputs();
    int s, presc, idx, thr;
    logic [15:0] v;
    logic [3:0]  dpv;
    logic        blz, blank;
    logic [3:0]  nib;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;
    logic        e_fd;
    s     = st - 1;
    presc = s % P;
    idx   = (s / P) % N;
    active_for(s / FRAME, v, dpv, blz);
    thr   = ((int'(bright) + 1) * P) / 16;
    nib   = 4'(v >> (4 * idx));
    blank = blz && (idx > 0) && ((v >> (4 * idx)) == 16'h0);
    if (presc < thr) begin
      e_seg = blank ? 7'h7F : ~HEX_TBL[nib];
      e_dp  = ~dpv[idx];
      e_dig = (presc == P - 1) ? 4'hF : ~(4'b0001 << idx);
    end else begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_dig = 4'hF;
    end
    e_fd = (s > 0) && (s % FRAME == 0);
    check_eq("seg_n", 32'(seg_n), 32'(e_seg));
    check_eq("dp_n", 32'(dp_n), 32'(e_dp));
    check_eq("dig_sel_n", 32'(dig_sel_n), 32'(e_dig));
    check_eq("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    check_eq({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    check_eq({tag, "_dig_sel_n"}, 32'(dig_sel_n), 32'hF);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    st++;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    value = v; dp_in = dp; blank_lz = blz; load = 1'b1;
    hist.push_back('{s: st, v: v, dp: dp, blz: blz});
    step();
    load = 1'b0;
  endtask

  task automatic run_to_state(input int slot_pos);
    while (st % FRAME != slot_pos) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    int          k;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    // A load while held in reset must not reach any buffer.
    @(negedge clk);
    value = 16'h9999; dp_in = 4'hF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    st = 0;
    rst_n = 1'b1;

    do_load(16'h12AF, 4'b0100, 1'b0);
    run(2 * FRAME);

    do_load(16'h0005, 4'b0000, 1'b1);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0000, 1'b1);
    run(2 * FRAME);

    run_to_state(P + 3);
    do_load(16'h1111, 4'b0000, 1'b0);
    run(FRAME + 8);
    run_to_state(FRAME - 1);
    do_load(16'h2222, 4'b1001, 1'b0);
    run(FRAME);

    bright = 4'd3;
    run(2 * FRAME);
    bright = 4'd0;
    run(FRAME);
    bright = 4'hF;

    run_to_state(5);
    do_load(16'hAAAA, 4'b0011, 1'b0);
    run(7);
    do_load(16'hBBBB, 4'b1100, 1'b0);
    run(2 * FRAME);

    for (int c = 0; c < 20 * FRAME; c++) begin
      if ($urandom_range(0, 9) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rv = 16'($urandom);
        k  = $urandom_range(0, 4);
        if (k > 0) rv = rv & (16'hFFFF >> (4 * k));
        do_load(rv, 4'($urandom), 1'($urandom));
      end else begin
        step();
      end
    end

    bright = 4'hF;
    while ((st - 1) % FRAME != 2 * P + 8) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset("held_rst");
    @(negedge clk);
    hist.delete();
    st = 0;
    rst_n = 1'b1;
    run(2 * FRAME);
    do_load(16'h4C07, 4'b0010, 1'b1);
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
